// File: rtl/backward_layer_seq_pkg.sv
// Shared fixed-point definitions for the sequential backward layer:
// word defaults, saturating helpers, activation mode and FSM state encodings.
package backward_layer_seq_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_FRAC  = 8;

    typedef logic signed [DEF_WIDTH-1:0] fx_t;
    typedef logic signed [63:0]          wide_t;

    typedef enum logic {ACT_RELU, ACT_SIGMOID} act_e;
    typedef enum logic [1:0] {S_IDLE, S_DZ, S_MAC, S_DONE} state_e;

    function automatic wide_t sat(input wide_t v, input int unsigned width);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (width - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Arithmetic shift floors toward minus infinity before clamping.
    function automatic wide_t fx(input wide_t p, input int unsigned frac, input int unsigned width);
        return sat(p >>> frac, width);
    endfunction

endpackage

// File: rtl/backward_layer_seq_if.sv
// Handshake and operand/result bus of one backward layer.
interface backward_layer_seq_if #(
    parameter int unsigned N_OUT = 4,
    parameter int unsigned N_IN  = 8,
    parameter int unsigned WIDTH = 16
);
    logic                    start;
    logic                    accum_en;
    logic                    clear;
    logic signed [WIDTH-1:0] W       [N_OUT][N_IN];
    logic signed [WIDTH-1:0] z       [N_OUT];
    logic signed [WIDTH-1:0] act_out [N_OUT];
    logic signed [WIDTH-1:0] da_prev [N_OUT];
    logic signed [WIDTH-1:0] a_in    [N_IN];
    logic                    busy;
    logic                    done;
    logic signed [WIDTH-1:0] db      [N_OUT];
    logic signed [WIDTH-1:0] dW      [N_OUT][N_IN];
    logic signed [WIDTH-1:0] da      [N_IN];

    modport master (
        output start, accum_en, clear, W, z, act_out, da_prev, a_in,
        input  busy, done, db, dW, da
    );

    modport slave (
        input  start, accum_en, clear, W, z, act_out, da_prev, a_in,
        output busy, done, db, dW, da
    );
endinterface

// File: rtl/backward_layer_seq_fx_mac.sv
// Signed multiply with full-precision product, plus scaled, saturated and
// optionally accumulated fixed-point result.
module fx_mac
    import backward_layer_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned FRAC  = DEF_FRAC
) (
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    input  logic signed [WIDTH-1:0]   acc_in,
    input  logic                      accumulate,
    output logic signed [2*WIDTH-1:0] prod,
    output logic signed [WIDTH-1:0]   res
);
    wide_t scaled;

    always_comb begin
        prod   = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        scaled = fx(wide_t'(prod), FRAC, WIDTH);
        if (accumulate) scaled = sat(scaled + wide_t'(acc_in), WIDTH);
        res = WIDTH'(scaled);
    end
endmodule

// File: rtl/backward_layer_seq.sv
// Time-multiplexed dense-layer backward pass: dz/db, then dW and da over a
// shared multiplier pair, with optional mini-batch accumulation of dW/db.
module backward_layer_seq
    import backward_layer_seq_pkg::*;
#(
    parameter int unsigned N_OUT = 4,
    parameter int unsigned N_IN  = 8,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned FRAC  = DEF_FRAC,
    parameter string       ACT   = "relu"
) (
    input logic             clk,
    input logic             reset,
    backward_layer_seq_if.slave bus
);
    localparam act_e          MODE   = (ACT == "sigmoid") ? ACT_SIGMOID : ACT_RELU;
    localparam int unsigned   IW     = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned   JW     = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned   AW     = 2*WIDTH + $clog2(N_OUT);
    localparam logic [IW-1:0] I_LAST = IW'(N_OUT - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N_IN - 1);
    localparam wide_t         ONE    = wide_t'(1) <<< FRAC;

    typedef logic signed [WIDTH-1:0] word_t;

    state_e               state;
    logic [IW-1:0]        i;
    logic [JW-1:0]        j;
    logic                 accum;
    word_t                w_s   [N_OUT][N_IN];
    word_t                z_s   [N_OUT];
    word_t                act_s [N_OUT];
    word_t                dap_s [N_OUT];
    word_t                ain_s [N_IN];
    word_t                dz    [N_OUT];
    logic signed [AW-1:0] acc   [N_IN];

    word_t                a0, b0, acc0, a1, b1, res0, res1, slope, dz_new;
    logic                 acc_en0;
    logic signed [2*WIDTH-1:0] prod0, prod1;
    logic                 unused_prod;

    // DZ reuses the pair as a two-stage sigmoid-derivative chain; MAC feeds dW and da.
    always_comb begin
        slope   = WIDTH'(sat(ONE - wide_t'(act_s[i]), WIDTH));
        a0      = act_s[i];
        b0      = slope;
        acc0    = '0;
        acc_en0 = 1'b0;
        a1      = dap_s[i];
        b1      = res0;
        if (state == S_MAC) begin
            a0      = dz[i];
            b0      = ain_s[j];
            acc0    = bus.dW[i][j];
            acc_en0 = accum;
            a1      = w_s[i][j];
            b1      = dz[i];
        end
        if (MODE == ACT_SIGMOID) dz_new = res1;
        else                     dz_new = (z_s[i] > word_t'(0)) ? dap_s[i] : '0;
    end

    fx_mac #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mac_dw (
        .a(a0), .b(b0), .acc_in(acc0), .accumulate(acc_en0), .prod(prod0), .res(res0)
    );

    fx_mac #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mac_da (
        .a(a1), .b(b1), .acc_in('0), .accumulate(1'b0), .prod(prod1), .res(res1)
    );

    assign unused_prod = ^prod0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            i        <= '0;
            j        <= '0;
            accum    <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            for (int unsigned r = 0; r < N_OUT; r++) begin
                z_s[r]    <= '0;
                act_s[r]  <= '0;
                dap_s[r]  <= '0;
                dz[r]     <= '0;
                bus.db[r] <= '0;
                for (int unsigned c = 0; c < N_IN; c++) begin
                    w_s[r][c]    <= '0;
                    bus.dW[r][c] <= '0;
                end
            end
            for (int unsigned c = 0; c < N_IN; c++) begin
                ain_s[c]  <= '0;
                acc[c]    <= '0;
                bus.da[c] <= '0;
            end
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.clear) begin
                        for (int unsigned r = 0; r < N_OUT; r++) begin
                            bus.db[r] <= '0;
                            for (int unsigned c = 0; c < N_IN; c++) bus.dW[r][c] <= '0;
                        end
                    end else if (bus.start) begin
                        for (int unsigned r = 0; r < N_OUT; r++) begin
                            z_s[r]   <= bus.z[r];
                            act_s[r] <= bus.act_out[r];
                            dap_s[r] <= bus.da_prev[r];
                            for (int unsigned c = 0; c < N_IN; c++) w_s[r][c] <= bus.W[r][c];
                        end
                        for (int unsigned c = 0; c < N_IN; c++) begin
                            ain_s[c] <= bus.a_in[c];
                            acc[c]   <= '0;
                        end
                        accum    <= bus.accum_en;
                        i        <= '0;
                        j        <= '0;
                        bus.busy <= 1'b1;
                        state    <= S_DZ;
                    end
                end
                S_DZ: begin
                    dz[i]     <= dz_new;
                    bus.db[i] <= accum ? WIDTH'(sat(wide_t'(bus.db[i]) + wide_t'(dz_new), WIDTH))
                                       : dz_new;
                    if (i == I_LAST) begin
                        i     <= '0;
                        state <= S_MAC;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                S_MAC: begin
                    bus.dW[i][j] <= res0;
                    acc[j]       <= acc[j] + AW'(prod1);
                    if (j == J_LAST) begin
                        j <= '0;
                        if (i == I_LAST) begin
                            i     <= '0;
                            state <= S_DONE;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                S_DONE: begin
                    // da is scaled here, once every accumulator holds its final sum.
                    for (int unsigned c = 0; c < N_IN; c++)
                        bus.da[c] <= WIDTH'(fx(64'(acc[c]), FRAC, WIDTH));
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_backward_layer_seq.sv
// Directed and randomized checks of two layer instances (relu 2x2, sigmoid 4x8)
// against an integer reference model of the backward-pass rules.
module tb_backward_layer_seq;
    logic clk;
    logic rst_a;
    logic rst_b;

    int unsigned checks = 0;
    int unsigned errors = 0;

    int tW [4][8];
    int tz [4];
    int tact [4];
    int tdap [4];
    int tain [8];

    longint mdb [2][4];
    longint mdW [2][4][8];
    longint mda [2][8];

    backward_layer_seq_if #(.N_OUT(2), .N_IN(2), .WIDTH(16)) if_a ();
    backward_layer_seq_if #(.N_OUT(4), .N_IN(8), .WIDTH(16)) if_b ();

    backward_layer_seq #(.N_OUT(2), .N_IN(2), .WIDTH(16), .FRAC(8), .ACT("relu")) dut_a (
        .clk(clk), .reset(rst_a), .bus(if_a)
    );
    backward_layer_seq #(.N_OUT(4), .N_IN(8), .WIDTH(16), .FRAC(8), .ACT("sigmoid")) dut_b (
        .clk(clk), .reset(rst_b), .bus(if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint satm(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic longint floordiv256(input longint p);
        return (p - (((p % 256) + 256) % 256)) / 256;
    endfunction

    function automatic longint fxm(input longint p);
        return satm(floordiv256(p));
    endfunction

    function automatic int rnd16();
        return int'($signed(16'($urandom)));
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_run(input int d, input int n_out, input int n_in, input bit sig, input bit accum);
        longint dz;
        longint p;
        longint sum [8];
        for (int j = 0; j < 8; j++) sum[j] = 0;
        for (int i = 0; i < n_out; i++) begin
            if (sig) dz = fxm(longint'(tdap[i]) * fxm(longint'(tact[i]) * satm(256 - tact[i])));
            else     dz = (tz[i] > 0) ? longint'(tdap[i]) : 0;
            mdb[d][i] = accum ? satm(mdb[d][i] + dz) : dz;
            for (int j = 0; j < n_in; j++) begin
                p = fxm(dz * tain[j]);
                mdW[d][i][j] = accum ? satm(mdW[d][i][j] + p) : p;
                sum[j] += longint'(tW[i][j]) * dz;
            end
        end
        for (int j = 0; j < n_in; j++) mda[d][j] = satm(floordiv256(sum[j]));
    endtask

    task automatic model_zero(input int d, input bit keep_da);
        for (int i = 0; i < 4; i++) begin
            mdb[d][i] = 0;
            for (int j = 0; j < 8; j++) mdW[d][i][j] = 0;
        end
        if (!keep_da) for (int j = 0; j < 8; j++) mda[d][j] = 0;
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < 4; i++) begin
            tz[i]   = rnd16();
            tact[i] = int'($urandom_range(0, 256));
            tdap[i] = rnd16();
            for (int j = 0; j < 8; j++) tW[i][j] = rnd16();
        end
        for (int j = 0; j < 8; j++) tain[j] = rnd16();
    endtask

    task automatic check_a(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s.a.db[%0d]", tag, i), if_a.db[i], mdb[0][i]);
            for (int j = 0; j < 2; j++)
                check($sformatf("%s.a.dW[%0d][%0d]", tag, i, j), if_a.dW[i][j], mdW[0][i][j]);
        end
        for (int j = 0; j < 2; j++) check($sformatf("%s.a.da[%0d]", tag, j), if_a.da[j], mda[0][j]);
    endtask

    task automatic check_b(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s.b.db[%0d]", tag, i), if_b.db[i], mdb[1][i]);
            for (int j = 0; j < 8; j++)
                check($sformatf("%s.b.dW[%0d][%0d]", tag, i, j), if_b.dW[i][j], mdW[1][i][j]);
        end
        for (int j = 0; j < 8; j++) check($sformatf("%s.b.da[%0d]", tag, j), if_b.da[j], mda[1][j]);
    endtask

    task automatic load_a(input bit accum);
        for (int i = 0; i < 2; i++) begin
            if_a.z[i]       = 16'(tz[i]);
            if_a.act_out[i] = 16'(tact[i]);
            if_a.da_prev[i] = 16'(tdap[i]);
            for (int j = 0; j < 2; j++) if_a.W[i][j] = 16'(tW[i][j]);
        end
        for (int j = 0; j < 2; j++) if_a.a_in[j] = 16'(tain[j]);
        if_a.accum_en = accum;
    endtask

    task automatic load_b(input bit accum);
        for (int i = 0; i < 4; i++) begin
            if_b.z[i]       = 16'(tz[i]);
            if_b.act_out[i] = 16'(tact[i]);
            if_b.da_prev[i] = 16'(tdap[i]);
            for (int j = 0; j < 8; j++) if_b.W[i][j] = 16'(tW[i][j]);
        end
        for (int j = 0; j < 8; j++) if_b.a_in[j] = 16'(tain[j]);
        if_b.accum_en = accum;
    endtask

    task automatic run_a(input bit accum, input string tag);
        int unsigned n;
        model_run(0, 2, 2, 1'b0, accum);
        load_a(accum);
        if_a.start = 1'b1;
        @(posedge clk); #1;
        if_a.start = 1'b0;
        check({tag, ".a.busy"}, if_a.busy, 1);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (if_a.done !== 1'b1 && n < 200);
        check({tag, ".a.latency"}, n, 7);
        check({tag, ".a.busy_at_done"}, if_a.busy, 0);
        check_a(tag);
        @(posedge clk); #1;
        check({tag, ".a.done_pulse"}, if_a.done, 0);
    endtask

    task automatic run_b(input bit accum, input string tag, input bit hammer);
        int unsigned n;
        model_run(1, 4, 8, 1'b1, accum);
        load_b(accum);
        if_b.start = 1'b1;
        @(posedge clk); #1;
        if_b.start = 1'b0;
        check({tag, ".b.busy"}, if_b.busy, 1);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            if (hammer && (n == 5 || n == 20)) begin
                if_b.start      = 1'b1;
                if_b.accum_en   = ~accum;
                if_b.da_prev[0] = 16'($urandom);
                if_b.a_in[0]    = 16'($urandom);
                if_b.W[0][0]    = 16'($urandom);
            end else begin
                if_b.start = 1'b0;
            end
        end while (if_b.done !== 1'b1 && n < 200);
        if_b.start = 1'b0;
        check({tag, ".b.latency"}, n, 37);
        check({tag, ".b.busy_at_done"}, if_b.busy, 0);
        check_b(tag);
        @(posedge clk); #1;
        check({tag, ".b.done_pulse"}, if_b.done, 0);
    endtask

    task automatic set_t1();
        tz[0] = 256;   tz[1] = -256;
        tdap[0] = 512; tdap[1] = 512;
        tain[0] = 256; tain[1] = 128;
        tW[0][0] = 256; tW[0][1] = 0; tW[1][0] = 0; tW[1][1] = 256;
        tact[0] = 0;   tact[1] = 0;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.start = 1'b0; if_a.clear = 1'b0;
        if_b.start = 1'b0; if_b.clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tz[i] = 0; tact[i] = 0; tdap[i] = 0;
            for (int j = 0; j < 8; j++) tW[i][j] = 0;
        end
        for (int j = 0; j < 8; j++) tain[j] = 0;
        model_zero(0, 1'b0);
        model_zero(1, 1'b0);
        load_a(1'b0);
        load_b(1'b0);
        #12;
        check("reset.a.busy", if_a.busy, 0);
        check("reset.a.done", if_a.done, 0);
        check("reset.b.busy", if_b.busy, 0);
        check_a("reset");
        check_b("reset");
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Directed relu vector, then the same run accumulated.
        set_t1();
        run_a(1'b0, "t1");
        check("t1.db0", if_a.db[0], 512);
        check("t1.db1", if_a.db[1], 0);
        check("t1.dW01", if_a.dW[0][1], 256);
        check("t1.da0", if_a.da[0], 512);
        run_a(1'b1, "acc");
        check("acc.db0", if_a.db[0], 1024);
        check("acc.dW00", if_a.dW[0][0], 1024);
        check("acc.dW01", if_a.dW[0][1], 512);
        check("acc.da0", if_a.da[0], 512);

        if_a.clear = 1'b1;
        @(posedge clk); #1;
        if_a.clear = 1'b0;
        model_zero(0, 1'b1);
        check_a("clear");

        // clear wins over start in the same idle cycle.
        run_a(1'b0, "t1b");
        if_a.clear = 1'b1;
        if_a.start = 1'b1;
        @(posedge clk); #1;
        if_a.clear = 1'b0;
        if_a.start = 1'b0;
        model_zero(0, 1'b1);
        check("clrstart.busy", if_a.busy, 0);
        check_a("clrstart");
        repeat (3) @(posedge clk);
        #1 check("clrstart.done", if_a.done, 0);

        // Saturation at both rails.
        randomize_inputs();
        tz[0] = 1; tz[1] = 100;
        tdap[0] = 32767; tdap[1] = 32767;
        tain[0] = 32767; tain[1] = 32767;
        run_a(1'b0, "satp");
        check("satp.dW00", if_a.dW[0][0], 32767);
        tdap[0] = -32768; tdap[1] = -32768;
        run_a(1'b1, "satn1");
        run_a(1'b1, "satn2");
        check("satn2.dW00", if_a.dW[0][0], -32768);
        check("satn2.db0", if_a.db[0], -32768);

        repeat (6) begin
            randomize_inputs();
            run_a(1'($urandom), "rnd_a");
        end

        // Sigmoid at act=0.5.
        randomize_inputs();
        for (int i = 0; i < 4; i++) begin tact[i] = 128; tdap[i] = 256; end
        for (int j = 0; j < 8; j++) tain[j] = 256;
        run_b(1'b0, "t2", 1'b0);
        for (int i = 0; i < 4; i++) check($sformatf("t2.db[%0d]", i), if_b.db[i], 64);
        check("t2.dW37", if_b.dW[3][7], 64);

        randomize_inputs();
        run_b(1'b1, "hammer", 1'b1);
        repeat (3) begin
            randomize_inputs();
            run_b(1'($urandom), "rnd_b", 1'b0);
        end

        // Abort in the middle of MAC.
        randomize_inputs();
        load_b(1'b0);
        if_b.start = 1'b1;
        @(posedge clk); #1;
        if_b.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_b = 1'b1;
        #1;
        model_zero(1, 1'b0);
        check("midrst.busy", if_b.busy, 0);
        check("midrst.done", if_b.done, 0);
        check_b("midrst");
        @(negedge clk);
        rst_b = 1'b0;
        randomize_inputs();
        run_b(1'b1, "afterrst", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/backward_layer_seq.md
Name: backward_layer_seq

Overview:
- Time-multiplexed, parametrised backward-propagation engine for one dense layer. It is the successor to the fully parallel combinational backward layers.
- Given the upstream gradient da_prev, pre-activation z, activation output act_out, input activation a_in and weights W, it computes dz, db, dW and da using one shared multiplier pair under an FSM with start/done handshake.
- Adds two things the parallel layers lack: runtime gradient accumulation across samples (mini-batch) and saturating fixed-point arithmetic.
- Instantiated once per layer inside the backward network and chained through da/da_prev.

Parameters:
- N_OUT, 4, neurons in this layer (rows of W).
- N_IN, 8, neurons in previous layer (columns of W).
- WIDTH, 16, signed fixed-point word width.
- FRAC, 8, fractional bits (default Q8.8).
- ACT, "relu", activation derivative mode: "relu" or "sigmoid".

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- accum_en  in  1  sampled with start; 1 = add results into dW/db, 0 = overwrite.
- clear  in  1  zeroes dW/db; honoured only in IDLE.
- W  in  [N_OUT][N_IN]xWIDTH  layer weights.
- z  in  [N_OUT]xWIDTH  pre-activation.
- act_out  in  [N_OUT]xWIDTH  activation output (sigmoid derivative source).
- da_prev  in  [N_OUT]xWIDTH  gradient w.r.t. this layer's output.
- a_in  in  [N_IN]xWIDTH  layer input activation.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when all outputs are valid.
- db  out  [N_OUT]xWIDTH  bias gradient.
- dW  out  [N_OUT][N_IN]xWIDTH  weight gradient.
- da  out  [N_IN]xWIDTH  gradient passed to the previous layer.

Behaviour:
- Reset (async):
  - State goes to IDLE.
  - busy=0, done=0; db, dW, da, the internal dz array and the operand snapshot are all zero.
  - Reset mid-operation aborts immediately; no partial results are retained.
- States: IDLE -> DZ -> MAC -> DONE -> IDLE.
- IDLE:
  - clear=1 zeroes db/dW next edge. clear has priority over start in the same cycle; that start is ignored.
  - Otherwise start=1 snapshots W, z, act_out, da_prev, a_in and accum_en; zeroes the da accumulators; sets busy; goes to DZ.
  - Inputs may change freely after the snapshot.
- DZ: N_OUT cycles, index i=0..N_OUT-1, one per cycle.
  - relu: dz[i] = (z[i] > 0) ? da_prev[i] : 0. z=0 gives 0.
  - sigmoid: dz[i] = fx(da_prev[i] * fx(act_out[i] * (1.0 - act_out[i]))).
  - db[i] = dz[i] when accum_en=0; sat(db[i] + dz[i]) when accum_en=1.
- MAC: N_OUT*N_IN cycles; i outer, j inner, both counters wrap at N-1. Each cycle:
  - dW[i][j] = fx(dz[i] * a_in[j]), or sat(dW[i][j] + that) when accumulating.
  - acc[j] += W[i][j] * dz[i], held as a full-precision product in a (2*WIDTH + clog2(N_OUT))-bit accumulator.
  - On the last cycle, da[j] = sat(acc[j] >>> FRAC) for all j.
- DONE: one cycle; done=1, busy=0 that cycle; next state IDLE.
- Latency: done is high exactly N_OUT + N_OUT*N_IN + 1 cycles after the edge that accepted start (37 with defaults).
- Arithmetic rules:
  - fx(p) = arithmetic shift of the 2*WIDTH product right by FRAC (truncation toward minus infinity), then saturate.
  - sat clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. No wrap-around anywhere.
  - 1.0 is represented as 2^FRAC.
- start while busy is ignored. accum_en and clear are ignored while busy.
- Outputs hold their values from done until the next accepted start, clear or reset.
- da is rewritten on every run and is never accumulated.

Decomposition:
- Shared package: WIDTH/FRAC defaults, the fixed-point type, the fx/sat helper functions, the ACT mode encoding and the FSM state enum.
- One natural sub-module: fx_mac (signed multiply, shift, saturate, optional accumulate), used twice for the dW and da datapaths.

Test Plan:
- relu, N_OUT=2, N_IN=2, Q8.8; z={256,-256}, da_prev={512,512}, a_in={256,128}, W={{256,0},{0,256}}, accum_en=0 -> db={512,0}, dW={{512,256},{0,0}}, da={512,0}; done exactly 7 cycles after start.
- sigmoid, defaults; act_out all 128 (0.5), da_prev all 256 -> every dz=64 and db all 64; a_in all 256 -> dW all 64.
- Accumulate: run test 1 twice, second run with accum_en=1 -> db={1024,0}, dW={{1024,512},{0,0}}, da unchanged at {512,0}. Then pulse clear -> db and dW all 0.
- Saturation: da_prev=32767, z>0, a_in=32767 (relu) -> dW=32767. With accum_en=1, negative inputs -> clamps at -32768, never wraps.
- Handshake: start re-asserted while busy has no effect and done pulses once; clear and start in the same IDLE cycle -> clear applied, busy stays 0.
- Reset mid-MAC (cycle 10) -> busy, done and all outputs are 0 within the same cycle. A following start completes normally with correct results.
